// File: rtl/vx_fp_pack_pkg.sv
// rtl/vx_fp_pack_pkg.sv - shared FPU types and constants for the result packer
package vx_fp_pack_pkg;

  // Special-value class of an operand or result, decoded upstream
  typedef struct packed {
    logic is_nan;
    logic is_signaling;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // IEEE-754 exception flags produced by the packer
  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Result category decided in the first stage, consumed by the second
  typedef enum logic [2:0] {
    KIND_FINITE = 3'd0,
    KIND_NAN    = 3'd1,
    KIND_INF    = 3'd2,
    KIND_ZERO   = 3'd3,
    KIND_OVF    = 3'd4,
    KIND_UNF    = 3'd5
  } pack_kind_t;

  // Canonical quiet NaN {0, all-ones exponent, man MSB set}, right-aligned in 64 bits
  function automatic logic [63:0] canonical_nan(input int exp_bits, input int man_bits);
    return (((64'h1 << exp_bits) - 64'h1) << man_bits) | (64'h1 << (man_bits - 1));
  endfunction

endpackage

// File: rtl/vx_pipe_register.sv
// rtl/vx_pipe_register.sv - one pipeline stage: reset valid bit, unreset payload
module vx_pipe_register #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out
);

  // Valid bit clears on reset so in-flight entries are discarded
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_out <= 1'b0;
    end else if (enable) begin
      valid_out <= valid_in;
    end
  end

  // Payload only matters when valid, so it carries no reset
  always_ff @(posedge clk) begin
    if (enable) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/vx_fp_pack.sv
// rtl/vx_fp_pack.sv - two-stage per-lane IEEE-754 result packer with backpressure
module vx_fp_pack
  import vx_fp_pack_pkg::*;
#(
  parameter int MAN_BITS  = 23,
  parameter int EXP_BITS  = 8,
  parameter int LANES     = 1,
  parameter int TAG_WIDTH = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               valid_in,
  output logic                               ready_in,
  input  logic [LANES-1:0]                   sign_in,
  input  logic [LANES*(EXP_BITS+2)-1:0]      exp_in,
  input  logic [LANES*(MAN_BITS+1)-1:0]      man_in,
  input  fp_class_t [LANES-1:0]              clss_in,
  input  logic [TAG_WIDTH-1:0]               tag_in,
  output logic                               valid_out,
  input  logic                               ready_out,
  output logic [LANES*(1+EXP_BITS+MAN_BITS)-1:0] data_out,
  output fflags_t [LANES-1:0]                fflags_out,
  output logic [TAG_WIDTH-1:0]               tag_out
);

  localparam int FW  = 1 + EXP_BITS + MAN_BITS;
  localparam int EW  = EXP_BITS + 2;
  localparam int SHW = $clog2(MAN_BITS + 2);
  // S1 lane payload: kind, sign, signaling, exp field, mantissa, shift
  localparam int S1L = 3 + 1 + 1 + EXP_BITS + MAN_BITS + 1 + SHW;
  // S2 lane payload: packed word and flags
  localparam int S2L = FW + 4;
  localparam int S1W = LANES * S1L + TAG_WIDTH;
  localparam int S2W = LANES * S2L + TAG_WIDTH;

  localparam logic [FW-1:0]        QNAN      = FW'(canonical_nan(EXP_BITS, MAN_BITS));
  localparam logic signed [EW-1:0] MAX_EXP   = EW'((1 << EXP_BITS) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO  = EW'(0);
  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
  // At or below this exponent every mantissa bit is shifted out
  localparam logic signed [EW-1:0] EXP_FLUSH = EW'(-MAN_BITS);

  logic           s1_en, s1_v;
  logic           s2_en, s2_v;
  logic [S1W-1:0] s1_d, s1_q;
  logic [S2W-1:0] s2_d, s2_q;

  // A stage advances when empty or when its consumer advances
  assign s2_en    = !s2_v || ready_out;
  assign s1_en    = !s1_v || s2_en;
  assign ready_in = reset && s1_en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [EW-1:0] exp_s;
    logic [MAN_BITS:0]    man;
    fp_class_t            clss;
    pack_kind_t           kind;
    logic [SHW-1:0]       shamt;
    logic signed [EW-1:0] shift_full;

    assign exp_s      = exp_in[i*EW +: EW];
    assign man        = man_in[i*(MAN_BITS+1) +: MAN_BITS+1];
    assign clss       = clss_in[i];
    assign shift_full = EXP_ONE - exp_s;

    // Stage-1 decode: special class priority, range check, saturated shift
    always_comb begin
      kind  = KIND_FINITE;
      shamt = '0;
      if (clss.is_nan) begin
        kind = KIND_NAN;
      end else if (clss.is_inf) begin
        kind = KIND_INF;
      end else if (clss.is_zero) begin
        kind = KIND_ZERO;
      end else if (exp_s >= MAX_EXP) begin
        kind = KIND_OVF;
      end else if (exp_s <= EXP_ZERO) begin
        kind  = KIND_UNF;
        shamt = (exp_s <= EXP_FLUSH) ? SHW'(MAN_BITS + 1) : SHW'(shift_full);
      end
    end

    assign s1_d[i*S1L +: S1L] = {kind, sign_in[i], clss.is_signaling,
                                 exp_s[EXP_BITS-1:0], man, shamt};

    logic [2:0]          q_kind_raw;
    pack_kind_t          q_kind;
    logic                q_sign, q_snan;
    logic [EXP_BITS-1:0] q_exp;
    logic [MAN_BITS:0]   q_man;
    logic [SHW-1:0]      q_sh;
    logic [FW-1:0]       word;
    fflags_t             flags;

    assign {q_kind_raw, q_sign, q_snan, q_exp, q_man, q_sh} = s1_q[i*S1L +: S1L];
    assign q_kind = pack_kind_t'(q_kind_raw);

    // Stage-2 packing: denormalising shift with sticky loss detection
    always_comb begin
      word  = {q_sign, q_exp, q_man[MAN_BITS-1:0]};
      flags = '0;
      case (q_kind)
        KIND_NAN: begin
          word     = QNAN;
          flags.nv = q_snan;
        end
        KIND_INF:  word = {q_sign, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
        KIND_ZERO: word = {q_sign, {EXP_BITS{1'b0}}, {MAN_BITS{1'b0}}};
        KIND_OVF: begin
          word     = {q_sign, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
          flags.of = 1'b1;
          flags.nx = 1'b1;
        end
        KIND_UNF: begin
          word     = {q_sign, {EXP_BITS{1'b0}}, MAN_BITS'(q_man >> q_sh)};
          flags.nx = |(q_man & ~({(MAN_BITS+1){1'b1}} << q_sh));
          flags.uf = flags.nx;
        end
        default: ;
      endcase
    end

    assign s2_d[i*S2L +: S2L] = {word, flags};
    assign {data_out[i*FW +: FW], fflags_out[i]} = s2_q[i*S2L +: S2L];
  end

  assign s1_d[LANES*S1L +: TAG_WIDTH] = tag_in;
  assign s2_d[LANES*S2L +: TAG_WIDTH] = s1_q[LANES*S1L +: TAG_WIDTH];
  assign tag_out   = s2_q[LANES*S2L +: TAG_WIDTH];
  assign valid_out = s2_v;

  vx_pipe_register #(.DATAW(S1W)) u_s1 (
    .clk       (clk),
    .resetn    (reset),
    .enable    (s1_en),
    .valid_in  (valid_in),
    .data_in   (s1_d),
    .valid_out (s1_v),
    .data_out  (s1_q)
  );

  vx_pipe_register #(.DATAW(S2W)) u_s2 (
    .clk       (clk),
    .resetn    (reset),
    .enable    (s2_en),
    .valid_in  (s1_v),
    .data_in   (s2_d),
    .valid_out (s2_v),
    .data_out  (s2_q)
  );

endmodule

// File: doc/vx_fp_pack.md
VX_FP_PACK -- requirements
Module: VX_fp_pack

Interface
REQ-001 SHALL have parameter MAN_BITS, default 23, mantissa field width without the hidden bit.
REQ-002 SHALL have parameter EXP_BITS, default 8, exponent field width.
REQ-003 SHALL have parameter LANES, default 1, number of independent packing lanes.
REQ-004 SHALL have parameter TAG_WIDTH, default 1, width of the opaque request tag.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port valid_in  in  1  request valid.
REQ-008 SHALL have port ready_in  out  1  request accepted when valid_in and ready_in are both high.
REQ-009 SHALL have port sign_in  in  LANES  per-lane result sign.
REQ-010 SHALL have port exp_in  in  LANES*(EXP_BITS+2)  per-lane biased exponent, two's complement.
REQ-011 SHALL have port man_in  in  LANES*(MAN_BITS+1)  per-lane mantissa, MSB is the hidden bit.
REQ-012 SHALL have port clss_in  in  LANES x fp_class_t  per-lane special-value class.
REQ-013 SHALL have port tag_in  in  TAG_WIDTH  request tag.
REQ-014 SHALL have port valid_out  out  1  result valid.
REQ-015 SHALL have port ready_out  in  1  result consumed when valid_out and ready_out are both high.
REQ-016 SHALL have port data_out  out  LANES*(1+EXP_BITS+MAN_BITS)  per-lane packed IEEE-754 word, {sign, exp, man}.
REQ-017 SHALL have port fflags_out  out  LANES x fflags_t  per-lane exception flags (NV, OF, UF, NX).
REQ-018 SHALL have port tag_out  out  TAG_WIDTH  tag of the result.

Function
REQ-019 Each lane SHALL select its result by priority: is_nan, is_inf, is_zero, finite.
REQ-020 is_nan SHALL produce canonical quiet NaN: sign 0, exp all ones, man MSB 1, all other man bits 0; NV=1 iff is_signaling.
REQ-021 is_inf SHALL produce {sign_in, all ones, 0}; is_zero SHALL produce {sign_in, 0, 0}; all flags 0.
REQ-022 Finite with 1 <= exp_in <= 2^EXP_BITS-2 SHALL produce {sign_in, exp_in[EXP_BITS-1:0], man_in[MAN_BITS-1:0]}; flags 0.
REQ-023 Finite with exp_in >= 2^EXP_BITS-1 SHALL produce {sign_in, all ones, 0} with OF=1 and NX=1.
REQ-024 Finite with exp_in <= 0 SHALL right-shift man_in by (1-exp_in), truncating, and emit exp field 0; shift >= MAN_BITS+1 yields mantissa 0.
REQ-025 In the REQ-024 case, NX SHALL be 1 iff any nonzero bit is shifted out, and UF SHALL equal NX.
REQ-026 A finite input with man_in hidden bit 0 and exp_in > 0 SHALL be packed per REQ-022/023 without renormalisation.
REQ-027 Pipeline SHALL have 2 register stages: S1 registers class decode, overflow/underflow decision and shift amount; S2 registers the shifted mantissa, packed word and flags.
REQ-028 Latency SHALL be exactly 2 cycles from acceptance to valid_out when ready_out is held high; throughput 1 request/cycle.
REQ-029 Each stage SHALL advance when it is empty or the stage downstream advances; ready_in SHALL be 1 when S1 can advance.
REQ-030 With valid_out=1 and ready_out=0, data_out, fflags_out, tag_out and valid_out SHALL hold stable.
REQ-031 With ready_out low, the pipeline SHALL accept up to 2 requests, then deassert ready_in; no request SHALL be dropped or duplicated.
REQ-032 Acceptance and output consumption in the same cycle SHALL both take effect with no bubble.
REQ-033 tag_in SHALL travel with its request and appear unchanged on tag_out; lanes SHALL be independent.

Reset
REQ-034 While reset=0 at a clock edge, both stage valid bits SHALL clear; valid_out=0 the following cycle.
REQ-035 ready_in SHALL be 0 during reset and 1 the cycle after reset deasserts.
REQ-036 Data, flag and tag registers SHALL NOT require reset; in-flight requests at reset SHALL be discarded.

Structure
REQ-037 fp_class_t and fflags_t SHALL come from the shared FPU package; the canonical-NaN constant SHALL be defined there, parameterised by widths.
REQ-038 One pipeline register sub-module, VX_pipe_register (valid/data, enable, active-low reset), SHALL be instantiated per stage.

Verification
REQ-039 Single precision, is_nan with is_signaling=1, sign 1 -> data 0x7FC00000, NV=1, after 2 cycles.
REQ-040 exp_in=0x7F, man_in=0xC00000, sign 0 -> 0x3FC00000 (1.5), flags 0.
REQ-041 exp_in=0x0FF, man_in=0x800000, sign 1 -> 0xFF800000, OF=1, NX=1.
REQ-042 exp_in=-1, man_in=0x800001, sign 0 -> 0x00200000, UF=1, NX=1.
REQ-043 ready_out low 5 cycles, valid_in high with tags 1,2,3 -> ready_in drops after 2 accepts; on release tags 1,2,3 emerge in order, one per cycle.
REQ-044 reset=0 for 1 cycle with 2 requests in flight -> valid_out=0 next cycle; no stale result emerges.
